// File: rtl/MD_pkg.sv
// Shared MD definitions for the force-packet gather stage: packet and node-id
// widths, arbitration mode selectors and the buffered entry layout.
package MD_pkg;

  localparam int FRC_PKT_STRUCT_WIDTH = 32;
  localparam int NODE_ID_WIDTH        = 8;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef struct packed {
    logic [NODE_ID_WIDTH-1:0]        node_id;
    logic [FRC_PKT_STRUCT_WIDTH-1:0] frc;
  } frc_gather_entry_t;

  // Channel-index width; a single channel still gets a 1-bit index.
  function automatic int ch_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frc_gather_fifo.sv
// Per-channel register-based circular buffer. Writes into a full buffer are
// accepted only when the same cycle pops; otherwise they are dropped and flagged.
module frc_gather_fifo
  import MD_pkg::*;
#(
  parameter int W            = FRC_PKT_STRUCT_WIDTH + NODE_ID_WIDTH,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wdata,
  output logic [W-1:0] o_rdata,
  output logic         o_empty,
  output logic         o_afull,
  output logic         o_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  assign o_rdata = r_mem[r_rptr];
  assign o_empty = w_empty;
  assign o_afull = (r_count >= CNT_W'(AFULL_THRESH));
  assign o_drop  = i_push && w_full && !w_do_pop;

  // Storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pe_frc_gather.sv
// Merges NUM_CH per-PE neighbour-force streams into one registered output
// stream with valid/ready back-pressure, per-channel overflow flags and a packet counter.
module pe_frc_gather
  import MD_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = FRC_PKT_STRUCT_WIDTH,
  parameter int ID_W         = NODE_ID_WIDTH,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 4,
  parameter int ARB_MODE     = ARB_RR
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [NUM_CH*DATA_W-1:0]                   in_data,
  input  logic [NUM_CH*ID_W-1:0]                     in_node_id,
  input  logic [NUM_CH-1:0]                          in_valid,
  output logic [NUM_CH-1:0]                          in_almost_full,
  output logic [NUM_CH-1:0]                          in_overflow,
  output logic [DATA_W-1:0]                          out_data,
  output logic [ID_W-1:0]                            out_node_id,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       all_empty,
  output logic [31:0]                                pkt_count
);

  localparam int CH_W  = ch_idx_width(NUM_CH);
  localparam int SUM_W = CH_W + 2;
  localparam int ENT_W = ID_W + DATA_W;

  logic [ENT_W-1:0]  w_head [NUM_CH];
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_drop;
  logic [NUM_CH-1:0] w_pop;

  logic              w_load_en;
  logic              w_gnt_vld;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [SUM_W-1:0]  w_cand;
  logic [ENT_W-1:0]  w_sel;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [ID_W-1:0]   r_out_node;
  logic [CH_W-1:0]   r_out_ch;
  logic [CH_W-1:0]   r_last_grant;
  logic [31:0]       r_pkt_count;
  logic [NUM_CH-1:0] r_overflow;

  // Handshake: out_valid marks a held packet; it moves downstream on any edge
  // where out_valid && out_ready, and the register may reload in that same cycle.
  assign w_load_en = !r_out_valid || out_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    frc_gather_fifo #(
      .W            (ENT_W),
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AFULL_THRESH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (in_valid[i]),
      .i_pop   (w_pop[i]),
      .i_wdata ({in_node_id[i*ID_W +: ID_W], in_data[i*DATA_W +: DATA_W]}),
      .o_rdata (w_head[i]),
      .o_empty (w_empty[i]),
      .o_afull (in_almost_full[i]),
      .o_drop  (w_drop[i])
    );

    assign w_pop[i] = w_load_en && w_gnt_vld && (w_gnt_idx == CH_W'(i));
  end

  // Candidate order: fixed mode scans 0..NUM_CH-1; round-robin scans from
  // last_grant+1 with wrap. First non-empty candidate wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == ARB_FIXED) begin
        w_cand = SUM_W'(k);
      end else begin
        w_cand = SUM_W'(r_last_grant) + SUM_W'(k + 1);
        if (w_cand >= SUM_W'(NUM_CH)) begin
          w_cand = w_cand - SUM_W'(NUM_CH);
        end
      end
      if (!w_gnt_vld && !w_empty[w_cand[CH_W-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand[CH_W-1:0];
      end
    end
  end

  assign w_sel = w_head[w_gnt_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_node   <= '0;
      r_out_ch     <= '0;
      r_last_grant <= CH_W'(NUM_CH - 1);
      r_pkt_count  <= '0;
      r_overflow   <= '0;
    end else begin
      if (w_load_en) begin
        if (w_gnt_vld) begin
          r_out_valid  <= 1'b1;
          r_out_data   <= w_sel[DATA_W-1:0];
          r_out_node   <= w_sel[ENT_W-1:DATA_W];
          r_out_ch     <= w_gnt_idx;
          r_last_grant <= w_gnt_idx;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      if (r_out_valid && out_ready) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_node_id = r_out_node;
  assign out_ch      = r_out_ch;
  assign pkt_count   = r_pkt_count;
  assign in_overflow = r_overflow;
  assign all_empty   = (&w_empty) && !r_out_valid;

endmodule

// File: tb/tb_pe_frc_gather.sv
// Bench for pe_frc_gather: a round-robin and a fixed-priority instance share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_pe_frc_gather;
  import MD_pkg::*;

  localparam int NCH   = 4;
  localparam int DW    = FRC_PKT_STRUCT_WIDTH;
  localparam int IW    = NODE_ID_WIDTH;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 4;
  localparam int EW    = DW + IW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NCH*DW-1:0] in_data;
  logic [NCH*IW-1:0] in_node_id;
  logic [NCH-1:0]    in_valid;
  logic              out_ready;

  logic [NCH-1:0] rr_af, rr_ovf, fx_af, fx_ovf;
  logic [DW-1:0]  rr_data, fx_data;
  logic [IW-1:0]  rr_node, fx_node;
  logic [1:0]     rr_ch, fx_ch;
  logic           rr_valid, fx_valid, rr_empty, fx_empty;
  logic [31:0]    rr_cnt, fx_cnt;

  pe_frc_gather #(.NUM_CH(NCH), .DEPTH(DEPTH), .ARB_MODE(ARB_RR)) dut_rr (
    .clk(clk), .rst(rst), .in_data(in_data), .in_node_id(in_node_id),
    .in_valid(in_valid), .in_almost_full(rr_af), .in_overflow(rr_ovf),
    .out_data(rr_data), .out_node_id(rr_node), .out_ch(rr_ch),
    .out_valid(rr_valid), .out_ready(out_ready), .all_empty(rr_empty),
    .pkt_count(rr_cnt)
  );

  pe_frc_gather #(.NUM_CH(NCH), .DEPTH(DEPTH), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk(clk), .rst(rst), .in_data(in_data), .in_node_id(in_node_id),
    .in_valid(in_valid), .in_almost_full(fx_af), .in_overflow(fx_ovf),
    .out_data(fx_data), .out_node_id(fx_node), .out_ch(fx_ch),
    .out_valid(fx_valid), .out_ready(out_ready), .all_empty(fx_empty),
    .pkt_count(fx_cnt)
  );

  // ---------------- reference model (index 0 = RR, 1 = FIXED) ----------------
  logic [EW-1:0]  mq [2*NCH][$];
  bit             exp_valid [2];
  logic [DW-1:0]  exp_data  [2];
  logic [IW-1:0]  exp_node  [2];
  int             exp_ch    [2];
  int             exp_last  [2];
  logic [31:0]    exp_cnt   [2];
  logic [NCH-1:0] exp_ovf   [2];

  int n_vec;
  int n_err;
  int rr_log[$];
  int fx_log[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NCH; c++) mq[m*NCH+c].delete();
      exp_valid[m] = 1'b0;
      exp_data[m]  = '0;
      exp_node[m]  = '0;
      exp_ch[m]    = 0;
      exp_last[m]  = NCH - 1;
      exp_cnt[m]   = '0;
      exp_ovf[m]   = '0;
    end
  endtask

  // One clock edge of behaviour for mode m, from the inputs currently driven.
  task automatic model_step(input int m);
    int pre [NCH];
    int g;
    int c;
    bit load;
    bit xfer;
    logic [EW-1:0] e;
    xfer = exp_valid[m] && out_ready;
    load = !exp_valid[m] || out_ready;
    g = -1;
    for (int k = 0; k < NCH; k++) pre[k] = mq[m*NCH+k].size();
    if (load) begin
      for (int k = 0; k < NCH; k++) begin
        c = (m == 0) ? (exp_last[m] + 1 + k) % NCH : k;
        if (g < 0 && pre[c] > 0) g = c;
      end
    end
    if (g >= 0) begin
      e = mq[m*NCH+g].pop_front();
      exp_valid[m] = 1'b1;
      exp_data[m]  = e[DW-1:0];
      exp_node[m]  = e[EW-1:DW];
      exp_ch[m]    = g;
      exp_last[m]  = g;
    end else if (load) begin
      exp_valid[m] = 1'b0;
    end
    if (xfer) exp_cnt[m] = exp_cnt[m] + 32'd1;
    for (int k = 0; k < NCH; k++) begin
      if (in_valid[k]) begin
        if (pre[k] < DEPTH || g == k)
          mq[m*NCH+k].push_back({in_node_id[k*IW +: IW], in_data[k*DW +: DW]});
        else
          exp_ovf[m][k] = 1'b1;
      end
    end
  endtask

  task automatic check_dut(input int m);
    string p;
    logic [NCH-1:0] eaf;
    bit eempty;
    p = (m == 0) ? "rr" : "fx";
    eempty = !exp_valid[m];
    for (int c = 0; c < NCH; c++) begin
      eaf[c] = (mq[m*NCH+c].size() >= AF);
      if (mq[m*NCH+c].size() != 0) eempty = 1'b0;
    end
    check_eq({p, "_valid"}, 64'(m == 0 ? rr_valid : fx_valid), 64'(exp_valid[m]));
    if (exp_valid[m]) begin
      check_eq({p, "_data"}, 64'(m == 0 ? rr_data : fx_data), 64'(exp_data[m]));
      check_eq({p, "_node"}, 64'(m == 0 ? rr_node : fx_node), 64'(exp_node[m]));
      check_eq({p, "_ch"},   64'(m == 0 ? rr_ch : fx_ch),     64'(exp_ch[m]));
    end
    check_eq({p, "_afull"},     64'(m == 0 ? rr_af : fx_af),       64'(eaf));
    check_eq({p, "_overflow"},  64'(m == 0 ? rr_ovf : fx_ovf),     64'(exp_ovf[m]));
    check_eq({p, "_all_empty"}, 64'(m == 0 ? rr_empty : fx_empty), 64'(eempty));
    check_eq({p, "_pkt_count"}, 64'(m == 0 ? rr_cnt : fx_cnt),     64'(exp_cnt[m]));
  endtask

  task automatic check_reset(input string t);
    check_eq({t, "_rr_valid"}, 64'(rr_valid), 64'(0));
    check_eq({t, "_rr_data"},  64'(rr_data),  64'(0));
    check_eq({t, "_rr_node"},  64'(rr_node),  64'(0));
    check_eq({t, "_rr_ch"},    64'(rr_ch),    64'(0));
    check_eq({t, "_rr_af"},    64'(rr_af),    64'(0));
    check_eq({t, "_rr_ovf"},   64'(rr_ovf),   64'(0));
    check_eq({t, "_rr_cnt"},   64'(rr_cnt),   64'(0));
    check_eq({t, "_rr_empty"}, 64'(rr_empty), 64'(1));
    check_eq({t, "_fx_valid"}, 64'(fx_valid), 64'(0));
    check_eq({t, "_fx_ovf"},   64'(fx_ovf),   64'(0));
    check_eq({t, "_fx_cnt"},   64'(fx_cnt),   64'(0));
    check_eq({t, "_fx_empty"}, 64'(fx_empty), 64'(1));
  endtask

  // ---------------- driver tasks (entered and left at negedge) ----------------
  task automatic step_set(input logic [NCH-1:0] v, input logic rdy);
    in_valid  = v;
    out_ready = rdy;
    if (rr_valid && rdy) rr_log.push_back(int'(rr_ch));
    if (fx_valid && rdy) fx_log.push_back(int'(fx_ch));
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  endtask

  task automatic step(input logic [NCH-1:0] v, input logic rdy);
    for (int c = 0; c < NCH; c++) begin
      in_data[c*DW +: DW]    = DW'($urandom);
      in_node_id[c*IW +: IW] = IW'($urandom_range(0, 255));
    end
    step_set(v, rdy);
  endtask

  task automatic do_reset();
    in_valid  = '0;
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset("async");
    model_reset();
    @(negedge clk);
    check_reset("held");
    rst = 1'b1;
  endtask

  logic [NCH-1:0] rv;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
    in_data = '0;
    in_node_id = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("por");
    rst = 1'b1;

    // Single packet on ch2
    in_data = '0;
    in_node_id = '0;
    in_data[2*DW +: DW] = DW'(32'hA5);
    in_node_id[2*IW +: IW] = IW'(3);
    step_set(4'b0100, 1'b1);
    step(4'b0000, 1'b1);
    check_eq("single_ch",   64'(rr_ch),   64'(2));
    check_eq("single_data", 64'(rr_data), 64'(32'hA5));
    check_eq("single_node", 64'(rr_node), 64'(3));
    step(4'b0000, 1'b1);
    check_eq("single_cnt",   64'(rr_cnt),   64'(1));
    check_eq("single_empty", 64'(rr_empty), 64'(1));

    // Round-robin fairness with four backlogged channels
    do_reset();
    rr_log.delete();
    repeat (4) step(4'hF, 1'b0);
    repeat (20) step(4'h0, 1'b1);
    check_eq("rr_len", 64'(rr_log.size()), 64'(16));
    for (int k = 0; k < rr_log.size() && k < 16; k++)
      check_eq($sformatf("rr_order%0d", k), 64'(rr_log[k]), 64'(k % NCH));
    check_eq("rr_cnt16", 64'(rr_cnt), 64'(16));

    // Fixed priority with ch1 and ch3 backlogged
    do_reset();
    fx_log.delete();
    repeat (3) step(4'b1010, 1'b0);
    repeat (10) step(4'h0, 1'b1);
    check_eq("fx_len", 64'(fx_log.size()), 64'(6));
    for (int k = 0; k < fx_log.size() && k < 6; k++)
      check_eq($sformatf("fx_order%0d", k), 64'(fx_log[k]), 64'((k < 3) ? 1 : 3));

    // Back-pressure: held output, then one transfer
    do_reset();
    step(4'b0001, 1'b0);
    repeat (6) step(4'h0, 1'b0);
    step(4'h0, 1'b1);
    check_eq("bp_cnt", 64'(rr_cnt), 64'(1));

    // Overflow on ch0
    do_reset();
    repeat (18) step(4'b0001, 1'b0);
    check_eq("ovf_flag", 64'(rr_ovf), 64'(1));
    rr_log.delete();
    repeat (25) step(4'h0, 1'b1);
    check_eq("ovf_drain", 64'(rr_log.size()), 64'(17));
    check_eq("ovf_sticky", 64'(rr_ovf), 64'(1));

    // Reset mid-stream with packets buffered, then grants restart at ch0
    do_reset();
    repeat (2) step(4'hF, 1'b0);
    do_reset();
    step(4'hF, 1'b1);
    step(4'h0, 1'b1);
    check_eq("post_rst_valid", 64'(rr_valid), 64'(1));
    check_eq("post_rst_ch",    64'(rr_ch),    64'(0));

    // Random traffic and back-pressure
    repeat (1500) begin
      for (int c = 0; c < NCH; c++) rv[c] = ($urandom_range(0, 99) < 22);
      step(rv, $urandom_range(0, 3) != 0);
    end
    repeat (80) step(4'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
